// File: rtl/line_memory_pkg.sv
// Shared definitions for the line memory model: FSM encoding, default
// geometry and latency, and the counter width.
package line_memory_pkg;

    localparam int LINE_W_DEF      = 256;
    localparam int DEPTH_DEF       = 512;
    localparam int MEM_LATENCY_DEF = 10;
    localparam int CNT_W           = 8;

    // Byte offset bits below the line index (32-byte lines on the address bus)
    localparam int OFFSET_W        = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } mem_state_e;

    // Terminal count for the BUSY down-phase; kept here so every user of the
    // package derives the compare value the same way.
    function automatic logic [CNT_W-1:0] busy_last_cnt(input int latency);
        return CNT_W'(latency - 2);
    endfunction

endpackage

// File: rtl/line_memory_if.sv
// Request/response bundle between the dcache (master) and the line memory
// (slave). The requester holds enable_i until it sees ack_o.
interface line_memory_if
    import line_memory_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
);

    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (
        output addr_i,
        output data_i,
        output enable_i,
        output write_i,
        input  ack_o,
        input  data_o
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  enable_i,
        input  write_i,
        output ack_o,
        output data_o
    );

endinterface

// File: rtl/line_memory_line_ram.sv
// Single-port line storage: synchronous write, registered read. Kept as its
// own module so it can be replaced by a RAM macro. The storage itself is never
// reset; only the read register is, so data_o comes up as zero.
module line_ram
    import line_memory_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    // Array write; contents survive reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds the last line read until the next read access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory behind the dcache. One request at a time: the
// request is latched on acceptance, the FSM waits out MEM_LATENCY cycles, and
// the array access happens on the edge that enters ACK.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for enable_i; counter held at 0
// BUSY  | request latched; counter runs up to MEM_LATENCY-2
// ACK   | array accessed on entry; ack_o high for this one cycle
module line_memory
    import line_memory_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    line_memory_if.slave    bus
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = busy_last_cnt(MEM_LATENCY);

    mem_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              ack_q;

    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;

    logic              accept;
    logic              last_busy;
    logic [LINE_W-1:0] rd_line;

    // Address bits outside the index field are don't-care by design
    logic              unused_addr_bits;

    assign accept           = (state == IDLE) && bus.enable_i;
    assign last_busy        = (state == BUSY) && (cnt == LAST_CNT);
    assign unused_addr_bits = ^{bus.addr_i[31:OFFSET_W+IDX_W], bus.addr_i[OFFSET_W-1:0]};

    // Sequencing FSM with registered ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            ack_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    ack_q <= 1'b0;
                    if (bus.enable_i) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ack_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Request capture; later changes on the bus are ignored until next accept
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= bus.addr_i[OFFSET_W +: IDX_W];
            wdata_q <= bus.data_i;
            write_q <= bus.write_i;
        end
    end

    // Array is touched only on the edge leaving the last BUSY cycle, so an
    // aborted request (reset in BUSY) never writes and never updates data_o.
    line_ram #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (last_busy),
        .we    (write_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rd_line)
    );

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rd_line;

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: a table of requests with expected
// data_o values, plus hand sequences for back-to-back, reset abort and the
// minimum-latency build.
module tb_line_memory;

    localparam int LW = 256;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [LW-1:0] sb_q [$];

    line_memory_if #(.LINE_W(LW)) if0 ();
    line_memory_if #(.LINE_W(LW)) if1 ();

    line_memory #(.MEM_LATENCY(10), .LINE_W(LW), .DEPTH(512)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    line_memory #(.MEM_LATENCY(2), .LINE_W(LW), .DEPTH(512)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp_do;
    } vec_t;

    vec_t vecs [9];

    localparam logic [LW-1:0] PAT_A = {32{8'hA5}};
    localparam logic [LW-1:0] PAT_B = {8{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] PAT_C = {8{32'h1234_5678}};
    localparam logic [LW-1:0] PAT_D = {16{16'h0F0F}};
    localparam logic [LW-1:0] PAT_E = {4{64'hCAFE_F00D_0123_4567}};
    localparam logic [LW-1:0] PAT_P = {8{32'h5555_AAAA}};
    localparam logic [LW-1:0] PAT_Q = {8{32'h0BAD_F00D}};
    localparam logic [LW-1:0] PAT_F = {8{32'h7777_1111}};

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic check_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic pop_and_check(input string nm, input logic [LW-1:0] act);
        logic [LW-1:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ack with empty scoreboard", nm);
        end else begin
            exp = sb_q.pop_front();
            check_line(nm, act, exp);
        end
    endtask

    // One request on the L=10 instance. Bus inputs are scrambled after the
    // accept edge; latency is counted in edges from the drive point.
    task automatic run_req(input string nm, input logic wr, input logic [31:0] addr,
                           input logic [LW-1:0] wdata, input logic [LW-1:0] exp_do);
        int lat;
        if0.enable_i = 1'b1;
        if0.write_i  = wr;
        if0.addr_i   = addr;
        if0.data_i   = wdata;
        sb_q.push_back(exp_do);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if0.addr_i  = ~addr;
                if0.data_i  = ~wdata;
                if0.write_i = ~wr;
            end
        end while (!if0.ack_o && lat < 300);
        if0.enable_i = 1'b0;
        check_int({nm, " latency"}, lat, 10);
        pop_and_check({nm, " data_o"}, if0.data_o);
        @(posedge clk);
        #1;
        check_int({nm, " ack width"}, int'(if0.ack_o), 0);
    endtask

    initial begin
        int acks;
        int lat;

        vecs[0] = '{1'b1, 32'h0000_0040, PAT_A, '0};
        vecs[1] = '{1'b0, 32'h0000_0040, '0,    PAT_A};
        vecs[2] = '{1'b1, 32'h0000_4040, PAT_B, PAT_A};
        vecs[3] = '{1'b0, 32'h0000_0040, '0,    PAT_B};
        vecs[4] = '{1'b1, 32'h0000_3FE5, PAT_C, PAT_B};
        vecs[5] = '{1'b0, 32'hFFFF_FFE0, '0,    PAT_C};
        vecs[6] = '{1'b1, 32'h0000_0020, PAT_D, PAT_C};
        vecs[7] = '{1'b0, 32'h0000_0021, '0,    PAT_D};
        vecs[8] = '{1'b0, 32'h8000_0047, '0,    PAT_B};

        rst          = 1'b0;
        if0.enable_i = 1'b0;
        if0.write_i  = 1'b0;
        if0.addr_i   = '0;
        if0.data_i   = '0;
        if1.enable_i = 1'b0;
        if1.write_i  = 1'b0;
        if1.addr_i   = '0;
        if1.data_i   = '0;
        #22;
        rst = 1'b1;

        // Idle after reset: no ack, data_o zero
        acks = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (if0.ack_o) acks++;
        end
        check_int("idle ack count", acks, 0);
        check_line("idle data_o", if0.data_o, '0);

        // Table of single requests
        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_do);
        end

        // Back-to-back: write held, switched to read in the ack cycle
        if0.enable_i = 1'b1;
        if0.write_i  = 1'b1;
        if0.addr_i   = 32'h0000_0060;
        if0.data_i   = PAT_E;
        sb_q.push_back(PAT_B);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!if0.ack_o && lat < 300);
        check_int("b2b write latency", lat, 10);
        pop_and_check("b2b write data_o", if0.data_o);
        if0.write_i = 1'b0;
        sb_q.push_back(PAT_E);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!if0.ack_o && lat < 300);
        if0.enable_i = 1'b0;
        check_int("b2b ack spacing", lat, 11);
        pop_and_check("b2b read data_o", if0.data_o);
        @(posedge clk);
        #1;
        check_int("b2b ack width", int'(if0.ack_o), 0);

        // Reset abort during a write
        run_req("abort prior write", 1'b1, 32'h0000_0080, PAT_P, PAT_E);
        if0.enable_i = 1'b1;
        if0.write_i  = 1'b1;
        if0.addr_i   = 32'h0000_0080;
        if0.data_i   = PAT_Q;
        repeat (5) @(posedge clk);
        #2;
        rst          = 1'b0;
        if0.enable_i = 1'b0;
        #1;
        check_line("abort data_o in reset", if0.data_o, '0);
        check_int("abort ack in reset", int'(if0.ack_o), 0);
        #2;
        rst = 1'b1;
        acks = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (if0.ack_o) acks++;
        end
        check_int("abort ack count", acks, 0);
        run_req("abort readback", 1'b0, 32'h0000_0080, '0, PAT_P);

        // Minimum latency build: write then read
        for (int k = 0; k < 2; k++) begin
            if1.enable_i = 1'b1;
            if1.write_i  = (k == 0);
            if1.addr_i   = 32'h0000_0040;
            if1.data_i   = PAT_F;
            sb_q.push_back((k == 0) ? '0 : PAT_F);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!if1.ack_o && lat < 300);
            if1.enable_i = 1'b0;
            check_int($sformatf("lat2 op%0d latency", k), lat, 2);
            pop_and_check($sformatf("lat2 op%0d data_o", k), if1.data_o);
            @(posedge clk);
            #1;
            check_int($sformatf("lat2 op%0d ack width", k), int'(if1.ack_o), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 10, meaning cycles from request acceptance to ack_o (legal range 2..255).
REQ-002 SHALL have parameter LINE_W, default 256, meaning line width in bits.
REQ-003 SHALL have parameter DEPTH, default 512, meaning number of lines (power of two).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port addr_i  input  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5].
REQ-007 SHALL have port data_i  input  LINE_W  write line from the dcache.
REQ-008 SHALL have port enable_i  input  1  request valid, held by the requester until ack_o.
REQ-009 SHALL have port write_i  input  1  1 = write line, 0 = read line; qualified by enable_i.
REQ-010 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port data_o  output  LINE_W  read line, valid in the ack_o cycle.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-013 In IDLE with enable_i=1 SHALL latch addr_i line index, data_i and write_i, clear counter, and go to BUSY.
REQ-014 In IDLE with enable_i=0 SHALL stay in IDLE, counter held at 0.
REQ-015 In BUSY SHALL increment an 8-bit counter each cycle and go to ACK when the counter equals MEM_LATENCY-2.
REQ-016 ACK state SHALL assert ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be exactly MEM_LATENCY cycles: request accepted at edge N gives ack_o high in cycle after edge N+MEM_LATENCY-1.
REQ-018 Write SHALL commit the latched line to the array on the edge entering ACK; a read of that line accepted afterwards returns it.
REQ-019 Read SHALL load data_o from the array (latched index) on the edge entering ACK; data_o SHALL hold that value until the next read completes.
REQ-020 Write requests SHALL NOT modify data_o.
REQ-021 addr_i, data_i, write_i changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-022 enable_i sampled in BUSY or ACK SHALL be ignored; a request still high in the first IDLE cycle after ACK SHALL be accepted as a new request (back-to-back write-back then refill).
REQ-023 addr_i bits above the index field and bits [4:0] SHALL be ignored (address wraps modulo DEPTH lines).
REQ-024 Only one request SHALL be outstanding; no queueing.

Reset
REQ-025 rst_i=0 SHALL immediately force state IDLE, counter 0, ack_o 0, data_o 0, latched write_i 0.
REQ-026 Reset during BUSY SHALL abort the request with no array write and no ack_o.
REQ-027 Array contents SHALL NOT be reset; benches preload via hierarchical initialisation.

Structure
REQ-028 FSM state encoding, LINE_W and default DEPTH/MEM_LATENCY SHALL live in the shared package used by dcache_top.
REQ-029 The storage array SHALL be a sub-module line_ram (single port, synchronous write, registered read) so it can be swapped for a macro.
REQ-030 Implementation SHALL be one always block per sequential element group, no latches, no combinational paths from inputs to outputs.

Verification
REQ-031 Reset then idle 20 cycles -> ack_o stays 0, data_o = 0.
REQ-032 Write line 0xA5..A5 to addr 0x0000_0040 at cycle 0, read addr 0x0000_0040 after ack -> each ack exactly 10 cycles after acceptance, read data_o = 0xA5..A5.
REQ-033 Write addr 0x0000_4040 (DEPTH=512 wraps to index 2), read addr 0x0000_0040 -> returns written line.
REQ-034 enable_i held high with write_i=1 then switched to read in the ack cycle -> write commits, read accepted in next IDLE cycle, second ack 11 cycles after first.
REQ-035 rst_i pulsed low at cycle 5 of a write -> no ack_o, subsequent read of that line returns prior contents.
REQ-036 MEM_LATENCY=2 build, single read -> ack_o asserted 2 cycles after acceptance, one cycle wide.
